// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencing controller.
package led_seq_pkg;

    typedef enum logic [2:0] {
        OFF,
        SEED,
        PH_A,
        PH_B,
        SWITCH
    } seq_state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_R1   = 2'b01;
    localparam logic [1:0] MODE_R2   = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    localparam int unsigned DEF_TICK_DIV = 12_500_000;
    localparam int unsigned DEF_R1_STEPS = 8;
    localparam int unsigned DEF_R2_FILL  = 13;
    localparam int unsigned DEF_R2_CLEAR = 27;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider: counts 0..TICK_DIV-1 while not held, tick flags the wrap cycle.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int unsigned    CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = !clr && !hold && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (!hold) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_sequence_ctrl.sv
// Sequencing controller for the 27-LED datapath: strobe, phase counting, auto rule switching.
// Optional `pause` input is enabled by defining LED_SEQ_PAUSE_EN.
module led_sequence_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned R1_STEPS = DEF_R1_STEPS,
    parameter int unsigned R2_FILL  = DEF_R2_FILL,
    parameter int unsigned R2_CLEAR = DEF_R2_CLEAR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_sel,
    input  logic       run,
    output logic [1:0] dp_mode,
    output logic       dp_en,
    output logic       dp_rst,
    output logic       dp_lr,
    output logic       dp_sw,
    output logic       dp_auto_rst
`ifdef LED_SEQ_PAUSE_EN
    ,
    input  logic       pause
`endif
);

    localparam int unsigned        STEP_W = $clog2(max3(R1_STEPS, R2_FILL, R2_CLEAR) + 1);
    localparam logic [STEP_W-1:0]  N_R1   = STEP_W'(R1_STEPS);
    localparam logic [STEP_W-1:0]  N_R2F  = STEP_W'(R2_FILL);
    localparam logic [STEP_W-1:0]  N_R2C  = STEP_W'(R2_CLEAR);

    seq_state_t        r_state, w_next;
    logic [1:0]        r_msel, r_dp_mode, w_mode;
    logic [STEP_W-1:0] r_step, w_step, w_n_a, w_n_b;
    logic              r_dp_en, r_dp_rst, r_dp_lr, r_dp_sw, r_dp_auto_rst;
    logic              w_en, w_rst_p, w_lr, w_sw, w_auto;
    logic              w_clr, w_hold, w_tick, w_pause, w_rule2;

`ifdef LED_SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // SEED counts too, so the first strobe lands exactly TICK_DIV cycles after dp_rst.
    assign w_hold = w_pause || !run ||
                    !((r_state == SEED) || (r_state == PH_A) || (r_state == PH_B));

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .hold (w_hold),
        .tick (w_tick)
    );

    assign w_rule2 = (r_dp_mode == MODE_R2) || ((r_dp_mode == MODE_AUTO) && r_dp_sw);
    assign w_n_a   = w_rule2 ? N_R2F : N_R1;
    assign w_n_b   = w_rule2 ? N_R2C : N_R1;

    always_comb begin
        w_next  = r_state;
        w_mode  = r_dp_mode;
        w_step  = r_step;
        w_lr    = r_dp_lr;
        w_sw    = r_dp_sw;
        w_en    = 1'b0;
        w_rst_p = 1'b0;
        w_auto  = 1'b0;
        w_clr   = 1'b0;
        if (w_pause) begin
            w_next = r_state;
        end else if (r_msel != r_dp_mode) begin
            // Covers OFF exit too: dp_mode is always 00 while OFF.
            w_clr  = 1'b1;
            w_step = '0;
            w_lr   = 1'b0;
            w_sw   = 1'b0;
            w_mode = r_msel;
            if (r_msel == MODE_OFF) begin
                w_next = OFF;
            end else begin
                w_next  = SEED;
                w_rst_p = 1'b1;
            end
        end else begin
            case (r_state)
                OFF:  w_next = OFF;
                SEED: w_next = PH_A;
                PH_A: begin
                    if (r_step == w_n_a) begin
                        w_next = PH_B;
                        w_step = '0;
                        w_lr   = 1'b1;
                    end else if (w_tick) begin
                        w_en   = 1'b1;
                        w_step = r_step + STEP_W'(1);
                    end
                end
                PH_B: begin
                    if (r_step == w_n_b) begin
                        w_step = '0;
                        if (r_dp_mode == MODE_AUTO) begin
                            // Entering Rule 2 (sw 0->1) reseeds with lr=0, entering Rule 1 with lr=1.
                            w_next = SWITCH;
                            w_sw   = !r_dp_sw;
                            w_lr   = r_dp_sw;
                            w_auto = 1'b1;
                        end else begin
                            w_next = PH_A;
                            w_lr   = 1'b0;
                        end
                    end else if (w_tick) begin
                        w_en   = 1'b1;
                        w_step = r_step + STEP_W'(1);
                    end
                end
                SWITCH: begin
                    w_next = PH_A;
                    w_lr   = 1'b0;
                end
                default: w_next = OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= OFF;
            r_msel        <= MODE_OFF;
            r_dp_mode     <= MODE_OFF;
            r_step        <= '0;
            r_dp_en       <= 1'b0;
            r_dp_rst      <= 1'b0;
            r_dp_lr       <= 1'b0;
            r_dp_sw       <= 1'b0;
            r_dp_auto_rst <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_msel        <= mode_sel;
            r_dp_mode     <= w_mode;
            r_step        <= w_step;
            r_dp_en       <= w_en;
            r_dp_rst      <= w_rst_p;
            r_dp_lr       <= w_lr;
            r_dp_sw       <= w_sw;
            r_dp_auto_rst <= w_auto;
        end
    end

    assign dp_mode     = r_dp_mode;
    assign dp_en       = r_dp_en;
    assign dp_rst      = r_dp_rst;
    assign dp_lr       = r_dp_lr;
    assign dp_sw       = r_dp_sw;
    assign dp_auto_rst = r_dp_auto_rst;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Scoreboard bench for led_sequence_ctrl with TICK_DIV=4 and default step counts.
module tb_led_sequence_ctrl;

    localparam logic [2:0] K_EN   = 3'b001;
    localparam logic [2:0] K_AUTO = 3'b010;
    localparam logic [2:0] K_RST  = 3'b100;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       run      = 1'b1;
    logic [1:0] mode_sel = 2'b00;
    logic       r_pause  = 1'b0;
    logic [1:0] dp_mode;
    logic       dp_en, dp_rst, dp_lr, dp_sw, dp_auto_rst;

    led_sequence_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_sel    (mode_sel),
        .run         (run),
        .dp_mode     (dp_mode),
        .dp_en       (dp_en),
        .dp_rst      (dp_rst),
        .dp_lr       (dp_lr),
        .dp_sw       (dp_sw),
        .dp_auto_rst (dp_auto_rst)
`ifdef LED_SEQ_PAUSE_EN
        ,
        .pause       (r_pause)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] cyc;
        logic [1:0]  mode;
        logic        lr;
        logic        sw;
    } ev_t;

    ev_t  q[$];
    ev_t  act, exp_e;
    int   checks   = 0;
    int   errors   = 0;
    logic zero_req = 1'b0;
    logic done     = 1'b0;

    task automatic push_ev(input logic [2:0] k, input int c, input logic [1:0] m,
                           input logic lr, input logic sw);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.mode = m;
        e.lr   = lr;
        e.sw   = sw;
        q.push_back(e);
    endtask

    task automatic goto(input int t);
        if (t < cyc) begin
            $display("FAIL goto: now=%0d target=%0d", cyc, t);
            $fatal(1);
        end
        while (cyc != t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req_zero();
        zero_req = 1'b1;
        @(negedge clk);
        #1;
        zero_req = 1'b0;
    endtask

    // Monitor: every pulse pops one expected event; level checks on request.
    always @(negedge clk) begin
        if (done) begin
            while (q.size() > 0) begin
                exp_e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: got none, expected kind=%b cyc=%0d mode=%b lr=%b sw=%b",
                         exp_e.kind, exp_e.cyc, exp_e.mode, exp_e.lr, exp_e.sw);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else begin
            if (zero_req) begin
                checks++;
                if ({dp_mode, dp_en, dp_rst, dp_lr, dp_sw, dp_auto_rst} !== 7'b0) begin
                    errors++;
                    $display("FAIL outputs_zero cyc=%0d: got mode=%b en=%b rst=%b lr=%b sw=%b auto=%b, expected all 0",
                             cyc, dp_mode, dp_en, dp_rst, dp_lr, dp_sw, dp_auto_rst);
                end
            end
            if (dp_en === 1'b1 || dp_rst === 1'b1 || dp_auto_rst === 1'b1) begin
                act.kind = {dp_rst, dp_auto_rst, dp_en};
                act.cyc  = cyc;
                act.mode = dp_mode;
                act.lr   = dp_lr;
                act.sw   = dp_sw;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got kind=%b cyc=%0d mode=%b lr=%b sw=%b, expected no pulse",
                             act.kind, act.cyc, act.mode, act.lr, act.sw);
                end else begin
                    exp_e = q.pop_front();
                    if (act !== exp_e) begin
                        errors++;
                        $display("FAIL pulse: got kind=%b cyc=%0d mode=%b lr=%b sw=%b, expected kind=%b cyc=%0d mode=%b lr=%b sw=%b",
                                 act.kind, act.cyc, act.mode, act.lr, act.sw,
                                 exp_e.kind, exp_e.cyc, exp_e.mode, exp_e.lr, exp_e.sw);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus, expected done by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r1, r2, e, r3, a1, a2;

        // Reset state
        goto(2);
        req_zero();
        goto(3);
        rst = 1'b0;

        // Mode 01: seed, 8 left, 8 right, then left again without reseed
        goto(5);
        mode_sel = 2'b01;
        r1 = 7;
        push_ev(K_RST, r1, 2'b01, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++)
            push_ev(K_EN, r1 + 4 * k, 2'b01, logic'(((k - 1) / 8) % 2), 1'b0);

        // Mode 01 -> 10 on the cycle the 21st strobe would fire: strobe suppressed
        goto(r1 + 82);
        mode_sel = 2'b10;
        r2 = r1 + 84;
        push_ev(K_RST, r2, 2'b10, 1'b0, 1'b0);
        for (int k = 1; k <= 45; k++)
            push_ev(K_EN, r2 + 4 * k, 2'b10, logic'(k > 13 && k <= 40), 1'b0);

        // run=0 for 10 cycles with the divider at 2; it resumes from there
        e = r2 + 180;
        goto(e + 2);
        run = 1'b0;
        goto(e + 12);
        run = 1'b1;
        for (int k = 46; k <= 50; k++)
            push_ev(K_EN, e + 14 + 4 * (k - 46), 2'b10, 1'b0, 1'b0);

        // Automatic mode: R1 8+8, switch to R2, 13+27, switch back to R1
        goto(e + 31);
        mode_sel = 2'b11;
        r3 = e + 33;
        push_ev(K_RST, r3, 2'b11, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++)
            push_ev(K_EN, r3 + 4 * k, 2'b11, logic'(k > 8), 1'b0);
        a1 = r3 + 65;
        push_ev(K_AUTO, a1, 2'b11, 1'b0, 1'b1);
        for (int j = 1; j <= 40; j++)
            push_ev(K_EN, a1 + 4 * j, 2'b11, logic'(j > 13), 1'b1);
        a2 = a1 + 161;
        push_ev(K_AUTO, a2, 2'b11, 1'b1, 1'b0);

        // rst during SWITCH with mode_sel=00: everything 0 on the next edge and stays off
        goto(a2);
        rst      = 1'b1;
        mode_sel = 2'b00;
        goto(a2 + 1);
        req_zero();
        rst = 1'b0;
        goto(a2 + 20);
        req_zero();
        done = 1'b1;
    end

endmodule
